// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The slave modport is the unit's own view; master is the requester/memory side.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid_in;
  logic                  req_ready_out;
  logic                  req_store_in;
  logic [2:0]            req_funct3_in;
  logic [ADDR_WIDTH-1:0] req_addr_in;
  logic [DATA_WIDTH-1:0] req_wdata_in;
  logic                  resp_valid_out;
  logic                  resp_ready_in;
  logic [DATA_WIDTH-1:0] resp_data_out;
  logic                  resp_fault_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_wdata_out;
  logic                  mem_we_out;
  logic                  mem_re_out;
  logic [DATA_WIDTH-1:0] mem_rdata_in;

  modport slave (
    input  req_valid_in, req_store_in, req_funct3_in, req_addr_in, req_wdata_in,
           resp_ready_in, mem_rdata_in,
    output req_ready_out, resp_valid_out, resp_data_out, resp_fault_out,
           mem_addr_out, mem_wdata_out, mem_we_out, mem_re_out
  );

  modport master (
    output req_valid_in, req_store_in, req_funct3_in, req_addr_in, req_wdata_in,
           resp_ready_in, mem_rdata_in,
    input  req_ready_out, resp_valid_out, resp_data_out, resp_fault_out,
           mem_addr_out, mem_wdata_out, mem_we_out, mem_re_out
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit: one outstanding request, doubleword memory port,
// sub-word stores done as read-modify-write, all outputs registered.
module load_store_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input logic              clk_in,
  input logic              reset,
  load_store_unit_if.slave bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, WR, RESP} state_t;

  state_t                state;
  logic                  store_q;
  logic [2:0]            f3_q;
  logic [2:0]            off_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  illegal, misaligned, is_sd;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  // Decode the offered request: legality, alignment and the full-width store case
  always_comb begin
    illegal = bus.req_store_in ? bus.req_funct3_in[2] : (bus.req_funct3_in == 3'b111);
    case (bus.req_funct3_in[1:0])
      2'b01:   misaligned = bus.req_addr_in[0];
      2'b10:   misaligned = |bus.req_addr_in[1:0];
      2'b11:   misaligned = |bus.req_addr_in[2:0];
      default: misaligned = 1'b0;
    endcase
    is_sd = bus.req_store_in && (bus.req_funct3_in == 3'b011);
  end

  assign aligned_addr = {bus.req_addr_in[ADDR_WIDTH-1:3], 3'b000};

  // Load path: shift the captured word down to the lane offset, then size/extend
  logic [DATA_WIDTH-1:0] shifted, load_ext;
  assign shifted = bus.mem_rdata_in >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},         shifted[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}},        shifted[15:0]};
      3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}},        shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Store merge: lane mask of the access size moved to the byte offset
  logic [NUM_LANES-1:0]  size_mask, lane_mask;
  logic [DATA_WIDTH-1:0] wdata_sh, merged;

  always_comb begin
    case (f3_q[1:0])
      2'b00:   size_mask = NUM_LANES'(8'h01);
      2'b01:   size_mask = NUM_LANES'(8'h03);
      2'b10:   size_mask = NUM_LANES'(8'h0f);
      default: size_mask = '1;
    endcase
  end

  assign lane_mask = size_mask << off_q;
  assign wdata_sh  = wdata_q << {off_q, 3'b000};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = lane_mask[i] ? wdata_sh[8*i +: 8] : bus.mem_rdata_in[8*i +: 8];
  end

  // Control FSM; every bus output is a register updated on the transition
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state              <= IDLE;
      store_q            <= 1'b0;
      f3_q               <= 3'b000;
      off_q              <= 3'b000;
      wdata_q            <= '0;
      bus.req_ready_out  <= 1'b1;
      bus.resp_valid_out <= 1'b0;
      bus.resp_data_out  <= '0;
      bus.resp_fault_out <= 1'b0;
      bus.mem_addr_out   <= '0;
      bus.mem_wdata_out  <= '0;
      bus.mem_we_out     <= 1'b0;
      bus.mem_re_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_in) begin
            store_q           <= bus.req_store_in;
            f3_q              <= bus.req_funct3_in;
            off_q             <= bus.req_addr_in[2:0];
            wdata_q           <= bus.req_wdata_in;
            bus.req_ready_out <= 1'b0;
            bus.mem_addr_out  <= aligned_addr;
            if (illegal || misaligned) begin
              state              <= RESP;
              bus.resp_valid_out <= 1'b1;
              bus.resp_fault_out <= 1'b1;
              bus.resp_data_out  <= '0;
            end else if (is_sd) begin
              state             <= WR;
              bus.mem_we_out    <= 1'b1;
              bus.mem_wdata_out <= bus.req_wdata_in;
            end else begin
              state          <= RD_REQ;
              bus.mem_re_out <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          state          <= RD_CAP;
          bus.mem_re_out <= 1'b0;
        end
        RD_CAP: begin
          if (store_q) begin
            state             <= WR;
            bus.mem_we_out    <= 1'b1;
            bus.mem_wdata_out <= merged;
          end else begin
            state              <= RESP;
            bus.resp_valid_out <= 1'b1;
            bus.resp_fault_out <= 1'b0;
            bus.resp_data_out  <= load_ext;
          end
        end
        WR: begin
          state              <= RESP;
          bus.mem_we_out     <= 1'b0;
          bus.resp_valid_out <= 1'b1;
          bus.resp_fault_out <= 1'b0;
          bus.resp_data_out  <= '0;
        end
        RESP: begin
          if (bus.resp_ready_in) begin
            state              <= IDLE;
            bus.req_ready_out  <= 1'b1;
            bus.resp_valid_out <= 1'b0;
            bus.resp_fault_out <= 1'b0;
            bus.resp_data_out  <= '0;
            bus.mem_addr_out   <= '0;
            bus.mem_wdata_out  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a vector table of single transactions plus hand-written
// sequences for response stall and reset during a transaction.
module tb_load_store_unit;
  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  load_store_unit_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  load_store_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] word;
    logic [63:0] exp_data;
    logic        exp_fault;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs [15];

  int checks = 0;
  int errors = 0;

  // memory model and access tracking
  logic [63:0] cur_word = '0;
  logic        prev_re  = 1'b0;
  int          rd_cnt, wr_cnt, both_cnt;
  logic [63:0] wr_data, wr_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (bus.mem_re_out && bus.mem_we_out) both_cnt++;
    if (bus.mem_re_out) rd_cnt++;
    if (bus.mem_we_out) begin
      wr_cnt++;
      wr_data = bus.mem_wdata_out;
      wr_addr = bus.mem_addr_out;
    end
    bus.mem_rdata_in = prev_re ? cur_word : 64'h5a5a_5a5a_5a5a_5a5a;
    prev_re = bus.mem_re_out;
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd);
    bus.req_valid_in  = 1'b1;
    bus.req_store_in  = st;
    bus.req_funct3_in = f3;
    bus.req_addr_in   = a;
    bus.req_wdata_in  = wd;
  endtask

  // scramble request inputs after acceptance; the unit must use latched copies
  task automatic scramble();
    bus.req_valid_in  = 1'b0;
    bus.req_store_in  = ~bus.req_store_in;
    bus.req_funct3_in = 3'b111;
    bus.req_addr_in   = 64'hffff_ffff_ffff_ffff;
    bus.req_wdata_in  = 64'h0f0f_0f0f_0f0f_0f0f;
  endtask

  task automatic run(input int idx, input vec_t v);
    int lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    cur_word = v.word;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; wr_data = '0; wr_addr = '0;
    drive_req(v.store, v.f3, v.addr, v.wdata);
    tick();
    scramble();
    chk({tag, " mem_addr"}, bus.mem_addr_out, {v.addr[63:3], 3'b000});
    lat = 1;
    while (!bus.resp_valid_out && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, " data"}, bus.resp_data_out, v.exp_data);
    chk({tag, " fault"}, {63'b0, bus.resp_fault_out}, {63'b0, v.exp_fault});
    chk({tag, " reads"}, 64'(rd_cnt), 64'(v.exp_rd));
    chk({tag, " writes"}, 64'(wr_cnt), 64'(v.exp_wr));
    chk({tag, " re_we_overlap"}, 64'(both_cnt), 64'd0);
    if (v.exp_wr != 0) begin
      chk({tag, " wdata"}, wr_data, v.exp_wdata);
      chk({tag, " wr_addr"}, wr_addr, {v.addr[63:3], 3'b000});
    end
    bus.resp_ready_in = 1'b1;
    tick();
    bus.resp_ready_in = 1'b0;
    chk({tag, " back_idle"}, {62'b0, bus.req_ready_out, bus.resp_valid_out}, 64'b10);
  endtask

  initial begin
    logic [63:0] held;
    int lat;

    //            st  f3      addr   wdata                   word                    exp_data                fault lat rd wr exp_wdata
    vecs[0]  = '{1'b0, 3'b011, 64'h18, 64'h0,                 64'h1122334455667788, 64'h1122334455667788, 1'b0, 3, 1, 0, 64'h0};
    vecs[1]  = '{1'b0, 3'b000, 64'h0d, 64'h0,                 64'h000080ff00000000, 64'hffffffffffffff80, 1'b0, 3, 1, 0, 64'h0};
    vecs[2]  = '{1'b0, 3'b100, 64'h0d, 64'h0,                 64'h000080ff00000000, 64'h0000000000000080, 1'b0, 3, 1, 0, 64'h0};
    vecs[3]  = '{1'b1, 3'b001, 64'h22, 64'habcd,              64'h1111111111111111, 64'h0,                1'b0, 4, 1, 1, 64'h11111111abcd1111};
    vecs[4]  = '{1'b0, 3'b010, 64'h06, 64'h0,                 64'h1234567812345678, 64'h0,                1'b1, 1, 0, 0, 64'h0};
    vecs[5]  = '{1'b0, 3'b111, 64'h00, 64'h0,                 64'h1234567812345678, 64'h0,                1'b1, 1, 0, 0, 64'h0};
    vecs[6]  = '{1'b1, 3'b011, 64'h40, 64'hcafebabedeadbeef,  64'h0,                64'h0,                1'b0, 2, 0, 1, 64'hcafebabedeadbeef};
    vecs[7]  = '{1'b1, 3'b100, 64'h08, 64'h77,                64'h0,                64'h0,                1'b1, 1, 0, 0, 64'h0};
    vecs[8]  = '{1'b0, 3'b001, 64'h0a, 64'h0,                 64'h0123456789abcdef, 64'hffffffffffff89ab, 1'b0, 3, 1, 0, 64'h0};
    vecs[9]  = '{1'b0, 3'b101, 64'h0a, 64'h0,                 64'h0123456789abcdef, 64'h00000000000089ab, 1'b0, 3, 1, 0, 64'h0};
    vecs[10] = '{1'b0, 3'b010, 64'h04, 64'h0,                 64'h8765432100000000, 64'hffffffff87654321, 1'b0, 3, 1, 0, 64'h0};
    vecs[11] = '{1'b0, 3'b110, 64'h04, 64'h0,                 64'h8765432100000000, 64'h0000000087654321, 1'b0, 3, 1, 0, 64'h0};
    vecs[12] = '{1'b1, 3'b000, 64'h17, 64'hffffffffffffff5a,  64'h0011223344556677, 64'h0,                1'b0, 4, 1, 1, 64'h5a11223344556677};
    vecs[13] = '{1'b1, 3'b010, 64'h1c, 64'h00000000deadbeef,  64'haaaaaaaabbbbbbbb, 64'h0,                1'b0, 4, 1, 1, 64'hdeadbeefbbbbbbbb};
    vecs[14] = '{1'b1, 3'b001, 64'h23, 64'h1234,              64'h0,                64'h0,                1'b1, 1, 0, 0, 64'h0};

    bus.req_valid_in  = 1'b0;
    bus.req_store_in  = 1'b0;
    bus.req_funct3_in = 3'b000;
    bus.req_addr_in   = '0;
    bus.req_wdata_in  = '0;
    bus.resp_ready_in = 1'b0;
    bus.mem_rdata_in  = '0;

    // reset state
    reset = 1'b1;
    tick();
    tick();
    chk("reset ready", {63'b0, bus.req_ready_out}, 64'd1);
    chk("reset ctl", {59'b0, bus.resp_valid_out, bus.resp_fault_out, bus.mem_we_out,
                      bus.mem_re_out, 1'b0}, 64'd0);
    chk("reset data", bus.resp_data_out, 64'd0);
    chk("reset addr", bus.mem_addr_out, 64'd0);
    chk("reset wdata", bus.mem_wdata_out, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) run(i, vecs[i]);

    // response stall: outputs hold while resp_ready_in is low
    cur_word = 64'h1122334455667788;
    drive_req(1'b0, 3'b011, 64'h18, 64'h0);
    tick();
    scramble();
    bus.req_valid_in = 1'b1;
    lat = 1;
    while (!bus.resp_valid_out && lat < 20) begin
      tick();
      lat++;
    end
    chk("stall first", bus.resp_data_out, 64'h1122334455667788);
    held = bus.resp_data_out;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall hold", {61'b0, bus.resp_valid_out, bus.req_ready_out, bus.mem_re_out}, 64'b100);
      chk("stall data", bus.resp_data_out, held);
    end
    // ack with a request still offered: it must not be taken in the same cycle
    bus.resp_ready_in = 1'b1;
    tick();
    bus.resp_ready_in = 1'b0;
    bus.req_valid_in  = 1'b0;
    chk("ack idle", {61'b0, bus.resp_valid_out, bus.req_ready_out, bus.mem_re_out}, 64'b010);
    tick();
    chk("no accept", {62'b0, bus.mem_re_out, bus.mem_we_out}, 64'd0);

    // reset during the write phase of an SB
    cur_word = 64'hffff_ffff_ffff_ffff;
    drive_req(1'b1, 3'b000, 64'h01, 64'h42);
    tick();
    scramble();
    tick();
    tick();
    chk("sb in wr", {63'b0, bus.mem_we_out}, 64'd1);
    reset = 1'b1;
    wr_cnt = 0;
    tick();
    reset = 1'b0;
    chk("rst wr we", 64'(wr_cnt), 64'd0);
    chk("rst wr ctl", {61'b0, bus.resp_valid_out, bus.req_ready_out, bus.mem_we_out}, 64'b010);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst quiet", {62'b0, bus.resp_valid_out, bus.mem_we_out}, 64'd0);
    end
    chk("rst no write", 64'(wr_cnt), 64'd0);

    // reset wins over a simultaneous request
    drive_req(1'b0, 3'b011, 64'h30, 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid_in = 1'b0;
    chk("rst priority", {62'b0, bus.req_ready_out, bus.mem_re_out}, 64'b10);
    chk("rst priority addr", bus.mem_addr_out, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
